// File: rtl/md_sequencer_if.sv
// md_sequencer_if: EX-stage multiply/divide bundle between the pipeline and md_sequencer.
//   master: pipeline side, drives the EX instruction, flush and D-stage md flag.
//   slave : md_sequencer side, returns busy, stall request, HI/LO and mfhi/mflo read data.
interface md_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic            e_valid;
  logic [2:0]      e_op;
  logic [XLEN-1:0] e_a;
  logic [XLEN-1:0] e_b;
  logic            flush;
  logic            d_md;
  logic            busy;
  logic            stall_req;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] rd_data;

  modport master (
    output e_valid, e_op, e_a, e_b, flush, d_md,
    input  busy, stall_req, hi, lo, rd_data
  );

  modport slave (
    input  e_valid, e_op, e_a, e_b, flush, d_md,
    output busy, stall_req, hi, lo, rd_data
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/multu/div/divu unit beside the EX-stage ALU.
// Owns HI/LO, services mthi/mtlo/mfhi/mflo, and requests a D-stage stall while busy.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset, clears all state
//   md    - md_sequencer_if.slave: e_valid/e_op/e_a/e_b/flush/d_md in,
//           busy/hi/lo (registered), stall_req/rd_data (combinational) out
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_CYCLES);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t            state;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic              res_wr;

  logic              start;
  logic              mt_wr;
  logic [CNT_W-1:0]  lim;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic signed [XLEN-1:0] sa;
  logic signed [XLEN-1:0] sb;

  // Issue decode: arithmetic ops are e_op[2]==0, mthi/mtlo are 4/5.
  always_comb begin
    start = md.e_valid & ~md.flush & ~busy_q & ~md.e_op[2];
    mt_wr = md.e_valid & ~md.flush & ~busy_q &  md.e_op[2] & ~md.e_op[1];
    lim   = (state == MUL) ? MUL_LIM : DIV_LIM;
  end

  // Product: the low 64 bits of a sign- or zero-extended 64x64 multiply
  // give the signed or unsigned result respectively (e_op[0]=1 is unsigned).
  always_comb begin
    a_ext = {{XLEN{md.e_a[XLEN-1] & ~md.e_op[0]}}, md.e_a};
    b_ext = {{XLEN{md.e_b[XLEN-1] & ~md.e_op[0]}}, md.e_b};
    prod  = a_ext * b_ext;
  end

  // Quotient/remainder; zero divisor and INT_MIN/-1 are handled explicitly.
  always_comb begin
    sa  = md.e_a;
    sb  = md.e_b;
    quo = '0;
    rem = '0;
    if (md.e_b == '0) begin
      quo = '0;
      rem = '0;
    end else if (md.e_op[0]) begin
      quo = md.e_a / md.e_b;
      rem = md.e_a % md.e_b;
    end else if (md.e_a == INT_MIN && md.e_b == '1) begin
      quo = INT_MIN;
      rem = '0;
    end else begin
      quo = XLEN'(sa / sb);
      rem = XLEN'(sa % sb);
    end
  end

  // Sequencer: result is captured at start and committed to HI/LO when the count ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            cnt    <= CNT_W'(1);
            if (md.e_op[1]) begin
              state  <= DIV;
              res_hi <= rem;
              res_lo <= quo;
              res_wr <= (md.e_b != '0);
            end else begin
              state  <= MUL;
              res_hi <= prod[2*XLEN-1:XLEN];
              res_lo <= prod[XLEN-1:0];
              res_wr <= 1'b1;
            end
          end else if (mt_wr) begin
            if (md.e_op[0]) lo_q <= md.e_a;
            else            hi_q <= md.e_a;
          end
        end
        MUL, DIV: begin
          if (cnt == lim) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign md.busy      = busy_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.stall_req = md.d_md & (busy_q | start);
  assign md.rd_data   = (md.e_op == 3'd6) ? hi_q :
                        (md.e_op == 3'd7) ? lo_q : '0;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed test of md_sequencer. Completion results go through
// an expected-value queue checked by an independent monitor on busy falling.
`timescale 1ns/1ps
module tb_md_sequencer;

  logic clk;
  logic reset;
  md_sequencer_if md ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every busy 1->0 transition outside reset retires one expected {hi,lo}.
  initial begin
    logic prev;
    logic [63:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (prev && !md.busy) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_completion", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("sb_hi", 64'(md.hi), 64'(e[63:32]));
            check("sb_lo", 64'(md.lo), 64'(e[31:0]));
          end
        end
        prev = md.busy;
      end
    end
  end

  // Issue one arithmetic op (caller sits at a negedge) with d_md held high; counts
  // busy and stall cycles. inject_at>0 presents a second mult at that busy cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n, input logic [63:0] exp,
                        input int unsigned inject_at);
    int unsigned bc;
    int unsigned sc;
    bit done;
    exp_q.push_back(exp);
    md.e_valid = 1'b1; md.e_op = op; md.e_a = a; md.e_b = b;
    md.flush = 1'b0; md.d_md = 1'b1;
    #1;
    sc = md.stall_req ? 1 : 0;
    bc = 0;
    done = 1'b0;
    @(posedge clk); #1;
    md.e_valid = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      md.e_valid = 1'b0;
      if (md.busy) begin
        bc++;
        if (md.stall_req) sc++;
        if (bc == inject_at) begin
          md.e_valid = 1'b1; md.e_op = 3'd0; md.e_a = 32'd5; md.e_b = 32'd5;
        end
      end else begin
        done = 1'b1;
      end
    end
    check({name, "_completed"}, 64'(done), 64'(1));
    check({name, "_busy_cycles"}, 64'(bc), 64'(n));
    check({name, "_stall_cycles"}, 64'(sc), 64'(n + 1));
    md.d_md = 1'b0;
  endtask

  initial begin
    int unsigned bc;
    md.e_valid = 1'b0; md.e_op = 3'd0; md.e_a = '0; md.e_b = '0;
    md.flush = 1'b0; md.d_md = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    md.d_md = 1'b1; md.e_op = 3'd6; #1;
    check("rst_busy", 64'(md.busy), 64'(0));
    check("rst_hi", 64'(md.hi), 64'(0));
    check("rst_lo", 64'(md.lo), 64'(0));
    check("rst_stall", 64'(md.stall_req), 64'(0));
    check("rst_rd_data", 64'(md.rd_data), 64'(0));
    md.d_md = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);

    // Flushed mthi must not write
    md.e_valid = 1'b1; md.e_op = 3'd4; md.e_a = 32'h1234_5678; md.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_mthi_hi", 64'(md.hi), 64'hFFFF_FFFF);
    @(negedge clk);
    // Flushed mult must not start nor stall
    md.e_op = 3'd0; md.e_a = 32'd9; md.e_b = 32'd9; md.d_md = 1'b1; #1;
    check("flush_mult_stall", 64'(md.stall_req), 64'(0));
    @(posedge clk); #1;
    check("flush_mult_busy", 64'(md.busy), 64'(0));
    @(negedge clk);
    md.d_md = 1'b0; md.flush = 1'b0;
    md.e_op = 3'd4; md.e_a = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi_hi", 64'(md.hi), 64'h1234_5678);
    md.e_valid = 1'b0; md.e_op = 3'd6; #1;
    check("mfhi_rd_data", 64'(md.rd_data), 64'h1234_5678);
    @(negedge clk);
    md.e_valid = 1'b1; md.e_op = 3'd5; md.e_a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    md.e_valid = 1'b0; md.e_op = 3'd7; #1;
    check("mflo_rd_data", 64'(md.rd_data), 64'hCAFE_F00D);
    md.e_op = 3'd0; #1;
    check("rd_data_other_op", 64'(md.rd_data), 64'(0));
    @(negedge clk);

    // Reset mid-div at busy cycle 4: no result, immediate clear
    md.e_valid = 1'b1; md.e_op = 3'd2; md.e_a = 32'd100; md.e_b = 32'd7;
    @(posedge clk); #1;
    md.e_valid = 1'b0;
    bc = 0;
    for (int k = 0; k < 20 && bc < 4; k++) begin
      @(negedge clk);
      if (md.busy) bc++;
    end
    check("midop_reached_cycle4", 64'(bc), 64'(4));
    #1 reset = 1'b0; #1;
    check("midop_rst_busy", 64'(md.busy), 64'(0));
    check("midop_rst_hi", 64'(md.hi), 64'(0));
    check("midop_rst_lo", 64'(md.lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 5, 64'h0000_0000_0000_002A, 0);

    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 0);
    run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'h0000_0001_7FFF_FFFC, 0);
    run_op("mult_inject", 3'd0, 32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0001_0000_0000, 2);
    @(posedge clk); #1;
    check("inject_no_late_start", 64'(md.busy), 64'(0));

    repeat (2) @(negedge clk);
    check("sb_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the EX stage of the pipelined MIPS CPU. It sits beside the single-cycle ALU and runs mult, multu, div and divu over a fixed number of cycles. It owns the HI/LO registers and services mthi, mtlo, mfhi and mflo. It also generates the stall request the hazard unit uses to hold a D-stage multiply/divide-class instruction while the unit is busy.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu; legal range 1..15
- DIV_CYCLES, 10, busy duration of div/divu; legal range 1..15

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- e_valid  input  1  EX-stage instruction is a multiply/divide-class op
- e_op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=mfhi 7=mflo
- e_a  input  32  rs operand (forwarded)
- e_b  input  32  rt operand (forwarded)
- flush  input  1  exception/interrupt taken this cycle; EX instruction must have no effect
- d_md  input  1  D-stage instruction is multiply/divide-class (any of the 8 ops)
- busy  output  1  arithmetic in progress
- stall_req  output  1  hazard unit must stall D
- hi  output  32  HI register
- lo  output  32  LO register
- rd_data  output  32  mfhi → hi, mflo → lo, else 0; combinational on e_op

## Operation
- Start condition: start = e_valid & !flush & !busy & e_op ≤ 3.
- FSM states:
  - IDLE → MUL on start with op 0/1.
  - IDLE → DIV on start with op 2/3.
  - MUL/DIV → IDLE when the count reaches its limit.
- Start cycle: latch op and operands, and load the counter.
  - The product/quotient may be computed at start or during the count.
  - HI/LO must not change until completion.
- mult: {hi,lo} = signed 64-bit e_a×e_b.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (e_b=0): unit still goes busy for DIV_CYCLES; HI/LO unchanged at completion.
- mthi/mtlo:
  - Write hi/lo from e_a at the edge when e_valid & !flush & !busy.
  - Ignored while busy; hazard logic guarantees this does not occur.
- mfhi/mflo: pure read via rd_data; no state change.
- e_valid with op ≤ 3 while busy: ignored (hazard logic prevents it). The running operation is unaffected.
- flush: suppresses start and mthi/mtlo in that cycle only. An operation already running continues to completion; it belongs to an older, committed instruction.
- stall_req = d_md & (busy | start). Stall is independent of the D-stage op's data dependency.

## Timing
- Reset values:
  - state IDLE, busy=0, hi=0, lo=0, counter=0.
  - stall_req and rd_data follow their combinational equations.
- Asynchronous reset mid-operation aborts the operation; no result is written.
- Start accepted at edge T0.
- busy is high in the cycles after T0 through T0+N.
  - N = MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles.
- HI/LO are updated at the edge ending the last busy cycle, simultaneously with busy falling.
  - The new value is visible in the first cycle busy=0.
- stall_req covers the start cycle plus all N busy cycles (N+1 cycles for a back-to-back md instruction).
- mthi/mtlo latency is 1 edge; the new value is visible on hi/lo the next cycle.
- A new start is accepted in the first cycle with busy=0; back-to-back operations have no dead cycle.
- Counter: 4 bits; it never wraps within legal parameter ranges.

## Test plan
- mult e_a=0xFFFFFFFE(-2), e_b=3 → busy high 5 cycles, stall_req with d_md=1 for 6 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu 0xFFFFFFFF×0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 back-to-back → busy 10 cycles, hi/lo unchanged.
- Flush suppression:
  - mthi 0x12345678 with flush=1 → hi unchanged.
  - mult with flush=1 → busy stays 0, no stall_req.
  - Same mthi with flush=0 → hi=0x12345678 next cycle; mfhi gives rd_data=0x12345678.
- Reset mid-op: start div, assert reset low at busy cycle 4 → busy, hi, lo = 0 immediately. After release, IDLE and a new mult is accepted.
- Edge cases:
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Second mult issued while busy is ignored; the first result is intact.
